// File: rtl/tmu2_meshscan_if.sv
// Token bus from the mesh scanner to the vertex fetch stage.
// master = scanner (drives the token), slave = downstream consumer (drives ack).
interface tmu2_meshscan_if #(
    parameter int unsigned MESH_W  = 7,
    parameter int unsigned COORD_W = 12
);
    logic               pipe_stb_o;
    logic               pipe_ack_i;
    logic [MESH_W-1:0]  mx;
    logic [MESH_W-1:0]  my;
    logic [COORD_W-1:0] drx;
    logic [COORD_W-1:0] dry;

    modport master (
        output pipe_stb_o, mx, my, drx, dry,
        input  pipe_ack_i
    );

    modport slave (
        input  pipe_stb_o, mx, my, drx, dry,
        output pipe_ack_i
    );
endinterface

// File: rtl/tmu2_meshscan.sv
// TMU2 mesh scanner: walks the destination mesh in raster order, one token per square.
// Optional macro TMU2_MESHSCAN_ABORT_EN adds an abort input that ends a running frame early.
module tmu2_meshscan #(
    parameter int unsigned MESH_W  = 7,
    parameter int unsigned COORD_W = 12
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic [MESH_W-1:0]  hmeshlast,
    input  logic [MESH_W-1:0]  vmeshlast,
    input  logic [COORD_W-1:0] dst_hoffset,
    input  logic [COORD_W-1:0] dst_voffset,
    input  logic [COORD_W-1:0] dst_squarew,
    input  logic [COORD_W-1:0] dst_squareh,
    output logic               busy,
    output logic               done,
`ifdef TMU2_MESHSCAN_ABORT_EN
    input  logic               abort,
`endif
    tmu2_meshscan_if.master    pipe
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic               stb_q, stb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [MESH_W-1:0]  mx_q, mx_d, my_q, my_d;
    logic [MESH_W-1:0]  hlast_q, hlast_d, vlast_q, vlast_d;
    logic [COORD_W-1:0] drx_q, drx_d, dry_q, dry_d;
    logic [COORD_W-1:0] hoff_q, hoff_d, sqw_q, sqw_d, sqh_q, sqh_d;

    // Next-state, scan advance and output decode.
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        mx_d    = mx_q;
        my_d    = my_q;
        drx_d   = drx_q;
        dry_d   = dry_q;
        hlast_d = hlast_q;
        vlast_d = vlast_q;
        hoff_d  = hoff_q;
        sqw_d   = sqw_q;
        sqh_d   = sqh_q;

        unique case (state_q)
            IDLE: begin
                // done_q is still high in the first IDLE cycle; a start there is dropped
                if (start && !done_q) begin
                    hlast_d = hmeshlast;
                    vlast_d = vmeshlast;
                    hoff_d  = dst_hoffset;
                    sqw_d   = dst_squarew;
                    sqh_d   = dst_squareh;
                    if (hmeshlast == '0 || vmeshlast == '0) begin
                        state_d = DONE;
                    end else begin
                        mx_d    = '0;
                        my_d    = '0;
                        drx_d   = dst_hoffset;
                        dry_d   = dst_voffset;
                        stb_d   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (stb_q && pipe.pipe_ack_i) begin
                    if (mx_q != hlast_q - MESH_W'(1)) begin
                        mx_d  = mx_q + MESH_W'(1);
                        drx_d = drx_q + sqw_q;
                    end else if (my_q != vlast_q - MESH_W'(1)) begin
                        mx_d  = '0;
                        drx_d = hoff_q;
                        my_d  = my_q + MESH_W'(1);
                        dry_d = dry_q + sqh_q;
                    end else begin
                        stb_d   = 1'b0;
                        state_d = DONE;
                    end
                end
`ifdef TMU2_MESHSCAN_ABORT_EN
                // An ack in the same cycle has already been taken above; nothing follows it.
                if (abort) begin
                    stb_d   = 1'b0;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mx_q    <= '0;
            my_q    <= '0;
            drx_q   <= '0;
            dry_q   <= '0;
            hlast_q <= '0;
            vlast_q <= '0;
            hoff_q  <= '0;
            sqw_q   <= '0;
            sqh_q   <= '0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            drx_q   <= drx_d;
            dry_q   <= dry_d;
            hlast_q <= hlast_d;
            vlast_q <= vlast_d;
            hoff_q  <= hoff_d;
            sqw_q   <= sqw_d;
            sqh_q   <= sqh_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pipe.pipe_stb_o = stb_q;
    assign pipe.mx         = mx_q;
    assign pipe.my         = my_q;
    assign pipe.drx        = drx_q;
    assign pipe.dry        = dry_q;

endmodule
